// File: rtl/posit_div_denorm_seq_pkg.sv
// Shared posit sizing helpers for the denormalized-posit datapath blocks.
// Scale/fraction widths derive from the posit word width, ES and operand flavour.
package posit_div_denorm_seq_pkg;

  typedef enum logic [0:0] {
    NORMAL,
    PRODUCT
  } pd_type_e;

  // Signed scale spans regime (log2 N bits) plus ES exponent bits plus sign.
  function automatic int get_scale_width(input int n, input int es, input pd_type_e t);
    int w;
    w = $clog2(n) + es + 1;
    if (t == PRODUCT) w = w + 1;
    return w;
  endfunction

  function automatic int get_fraction_width(input int n, input int es, input pd_type_e t);
    int w;
    w = n - 3 - es;
    if (t == PRODUCT) w = 2 * w + 1;
    return w;
  endfunction

  function automatic int get_max_scale(input int n, input int es);
    return (2 ** es) * (n - 2);
  endfunction

endpackage

// File: rtl/posit_div_denorm_seq_frac_iter.sv
// Radix-2 restoring mantissa divider: one quotient bit per step, MSB first.
// Remainder stays below twice the divisor, so FW+2 bits are enough.
module posit_div_frac_iter #(
  parameter int FW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [FW:0]   dividend_i,
  input  logic [FW:0]   divisor_i,
  output logic [FW+3:0] q_o,
  output logic          rem_nonzero_o
);

  logic [FW+1:0] rem_q;
  logic [FW:0]   div_q;
  logic [FW+3:0] q_q;
  logic [FW+1:0] diff;
  logic          ge;

  assign diff = rem_q - {1'b0, div_q};
  assign ge   = (rem_q >= {1'b0, div_q});

  // After a subtract (or a failed compare) the remainder is below the divisor,
  // so the dropped top bit is always zero before the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      q_q   <= '0;
    end else if (load_i) begin
      rem_q <= {1'b0, dividend_i};
      div_q <= divisor_i;
      q_q   <= '0;
    end else if (step_i) begin
      q_q   <= {q_q[FW+2:0], ge};
      rem_q <= ge ? {diff[FW:0], 1'b0} : {rem_q[FW:0], 1'b0};
    end
  end

  assign q_o           = q_q;
  assign rem_nonzero_o = |rem_q;

endmodule

// File: rtl/posit_div_denorm_seq.sv
// Sequential divider on denormalized posits, emitting a denormalized quotient
// with guard/round/sticky for the downstream posit normalizer.
module posit_div_denorm_seq
  import posit_div_denorm_seq_pkg::*;
#(
  parameter int       POSIT_WIDTH = 32,
  parameter int       POSIT_ES    = 2,
  parameter pd_type_e PD_TYPE     = NORMAL,
  localparam int      SW          = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
  localparam int      FW          = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          a_sign,
  input  logic [SW-1:0] a_scale,
  input  logic [FW-1:0] a_fraction,
  input  logic          a_zero,
  input  logic          a_NaR,
  input  logic          b_sign,
  input  logic [SW-1:0] b_scale,
  input  logic [FW-1:0] b_fraction,
  input  logic          b_zero,
  input  logic          b_NaR,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [SW-1:0] out_scale,
  output logic [FW-1:0] out_fraction,
  output logic          out_guard,
  output logic          out_round,
  output logic          out_sticky,
  output logic          out_zero,
  output logic          out_NaR
);

  localparam int CW  = $clog2(FW + 5);
  localparam int SCW = SW + 2;
  localparam logic signed [SCW-1:0] MAX_S = SCW'(get_max_scale(POSIT_WIDTH, POSIT_ES));

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;
  logic [SW-1:0] a_scale_q, b_scale_q;
  logic          in_ready_q, out_valid_q, out_sign_q;
  logic [SW-1:0] out_scale_q;
  logic [FW-1:0] out_fraction_q;
  logic          out_guard_q, out_round_q, out_sticky_q, out_zero_q, out_NaR_q;

  logic          special, nar_in;
  logic          iter_load, iter_step;
  logic [FW+3:0] q;
  logic          rem_nz;

  logic signed [SCW-1:0] scale_ext;
  logic [SW-1:0] scale_d;
  logic [FW-1:0] frac_d;
  logic          guard_d, round_d, sticky_d;

  assign nar_in    = a_NaR | b_NaR | b_zero;
  assign special   = nar_in | a_zero;
  assign iter_load = (state_q == IDLE) & in_valid & ~special;
  assign iter_step = (state_q == DIV);

  posit_div_frac_iter #(.FW(FW)) u_iter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (iter_load),
    .step_i       (iter_step),
    .dividend_i   ({1'b1, a_fraction}),
    .divisor_i    ({1'b1, b_fraction}),
    .q_o          (q),
    .rem_nonzero_o(rem_nz)
  );

  // A quotient below 1 loses one bit of scale and shifts its rounding window down.
  always_comb begin
    scale_ext = {{2{a_scale_q[SW-1]}}, a_scale_q} - {{2{b_scale_q[SW-1]}}, b_scale_q}
              - {{(SCW-1){1'b0}}, ~q[FW+3]};
    if (q[FW+3]) begin
      frac_d   = q[FW+2:3];
      guard_d  = q[2];
      round_d  = q[1];
      sticky_d = q[0] | rem_nz;
    end else begin
      frac_d   = q[FW+1:2];
      guard_d  = q[1];
      round_d  = q[0];
      sticky_d = rem_nz;
    end
    scale_d = scale_ext[SW-1:0];
    if (scale_ext > MAX_S) begin
      scale_d  = MAX_S[SW-1:0];
      frac_d   = '0;
      guard_d  = 1'b0;
      round_d  = 1'b0;
      sticky_d = 1'b0;
    end else if (scale_ext < -MAX_S) begin
      scale_d  = SW'(-MAX_S);
      frac_d   = '0;
      guard_d  = 1'b0;
      round_d  = 1'b0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sign_q         <= 1'b0;
      a_scale_q      <= '0;
      b_scale_q      <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_sign_q     <= 1'b0;
      out_scale_q    <= '0;
      out_fraction_q <= '0;
      out_guard_q    <= 1'b0;
      out_round_q    <= 1'b0;
      out_sticky_q   <= 1'b0;
      out_zero_q     <= 1'b0;
      out_NaR_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= a_sign ^ b_sign;
            a_scale_q  <= a_scale;
            b_scale_q  <= b_scale;
            in_ready_q <= 1'b0;
            if (special) begin
              state_q        <= DONE;
              out_valid_q    <= 1'b1;
              out_sign_q     <= a_sign ^ b_sign;
              out_scale_q    <= '0;
              out_fraction_q <= '0;
              out_guard_q    <= 1'b0;
              out_round_q    <= 1'b0;
              out_sticky_q   <= 1'b0;
              out_NaR_q      <= nar_in;
              out_zero_q     <= ~nar_in;
            end else begin
              state_q <= DIV;
              cnt_q   <= CW'(FW + 3);
            end
          end
        end
        DIV: begin
          if (cnt_q == '0) state_q <= NORM;
          else cnt_q <= cnt_q - CW'(1);
        end
        NORM: begin
          state_q        <= DONE;
          out_valid_q    <= 1'b1;
          out_sign_q     <= sign_q;
          out_scale_q    <= scale_d;
          out_fraction_q <= frac_d;
          out_guard_q    <= guard_d;
          out_round_q    <= round_d;
          out_sticky_q   <= sticky_d;
          out_zero_q     <= 1'b0;
          out_NaR_q      <= 1'b0;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sign     = out_sign_q;
  assign out_scale    = out_scale_q;
  assign out_fraction = out_fraction_q;
  assign out_guard    = out_guard_q;
  assign out_round    = out_round_q;
  assign out_sticky   = out_sticky_q;
  assign out_zero     = out_zero_q;
  assign out_NaR      = out_NaR_q;

endmodule

// File: tb/tb_posit_div_denorm_seq.sv
// Directed bench for posit_div_denorm_seq at N=16, ES=1 (FW=12, SW=6).
// Expected quotients are hand-derived from the operand mantissas.
module tb_posit_div_denorm_seq;

  localparam int SW = 6;
  localparam int FW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          a_sign = 1'b0, b_sign = 1'b0;
  logic [SW-1:0] a_scale = '0, b_scale = '0;
  logic [FW-1:0] a_fraction = '0, b_fraction = '0;
  logic          a_zero = 1'b0, a_NaR = 1'b0, b_zero = 1'b0, b_NaR = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sign;
  logic [SW-1:0] out_scale;
  logic [FW-1:0] out_fraction;
  logic          out_guard, out_round, out_sticky, out_zero, out_NaR;

  int compared = 0;
  int mismatched = 0;
  int lat;

  posit_div_denorm_seq #(.POSIT_WIDTH(16), .POSIT_ES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_scale(a_scale), .a_fraction(a_fraction), .a_zero(a_zero), .a_NaR(a_NaR),
    .b_sign(b_sign), .b_scale(b_scale), .b_fraction(b_fraction), .b_zero(b_zero), .b_NaR(b_NaR),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_scale(out_scale), .out_fraction(out_fraction),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .out_zero(out_zero), .out_NaR(out_NaR)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveOperands(input logic as, input logic [SW-1:0] asc, input logic [FW-1:0] af,
                               input logic az, input logic an,
                               input logic bs, input logic [SW-1:0] bsc, input logic [FW-1:0] bf,
                               input logic bz, input logic bn);
    a_sign = as; a_scale = asc; a_fraction = af; a_zero = az; a_NaR = an;
    b_sign = bs; b_scale = bsc; b_fraction = bf; b_zero = bz; b_NaR = bn;
  endtask

  // Hands one operand pair over and returns the accept-to-valid latency,
  // counting the accept edge itself as cycle 1.
  task automatic applyStimulus(input logic as, input logic [SW-1:0] asc, input logic [FW-1:0] af,
                               input logic az, input logic an,
                               input logic bs, input logic [SW-1:0] bsc, input logic [FW-1:0] bf,
                               input logic bz, input logic bn, output int latency);
    int guard;
    driveOperands(as, asc, af, az, an, bs, bsc, bf, bz, bn);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    latency = 1;
    while (!out_valid && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
    if (!out_valid) checkOutput("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic expectResult(input string tag, input int lat_exp, input logic sign,
                              input logic [SW-1:0] scale, input logic [FW-1:0] frac,
                              input logic [2:0] grs, input logic zero, input logic nar);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    checkOutput({tag, "_sign"}, 32'(out_sign), 32'(sign));
    checkOutput({tag, "_scale"}, 32'(out_scale), 32'(scale));
    checkOutput({tag, "_frac"}, 32'(out_fraction), 32'(frac));
    checkOutput({tag, "_grs"}, 32'({out_guard, out_round, out_sticky}), 32'(grs));
    checkOutput({tag, "_zero"}, 32'(out_zero), 32'(zero));
    checkOutput({tag, "_nar"}, 32'(out_NaR), 32'(nar));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_scale", 32'(out_scale), 32'd0);
    checkOutput("rst_frac", 32'(out_fraction), 32'd0);
    checkOutput("rst_flags", 32'({out_sign, out_guard, out_round, out_sticky, out_zero, out_NaR}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0 / 1.0
    applyStimulus(0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0, lat);
    expectResult("one_one", FW + 6, 0, 6'd0, 12'h000, 3'b000, 0, 0);
    consume("one_one");

    // 1.0 / 1.5 = 0.666..
    applyStimulus(0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h800, 0, 0, lat);
    expectResult("one_1p5", FW + 6, 0, 6'h3F, 12'h555, 3'b011, 0, 0);
    consume("one_1p5");

    // -3.0 / 2.0 = -1.5
    applyStimulus(1, 6'd1, 12'h800, 0, 0, 0, 6'd1, 12'h000, 0, 0, lat);
    expectResult("m3_2", FW + 6, 1, 6'd0, 12'h800, 3'b000, 0, 0);
    consume("m3_2");

    // 1.75*2^2 / 1.25*2^-3: mantissa 1.4, scale 5
    applyStimulus(0, 6'd2, 12'hC00, 0, 0, 1, 6'h3D, 12'h400, 0, 0, lat);
    expectResult("q1p4", FW + 6, 1, 6'd5, 12'h666, 3'b011, 0, 0);
    consume("q1p4");

    // 1.25 / 1.75 = 5/7, renormalised to 10/7 with scale -1
    applyStimulus(0, 6'd0, 12'h400, 0, 0, 0, 6'd0, 12'hC00, 0, 0, lat);
    expectResult("q5_7", FW + 6, 0, 6'h3F, 12'h6DB, 3'b011, 0, 0);
    consume("q5_7");

    // Special operands bypass the divider
    applyStimulus(0, 6'd3, 12'h123, 0, 0, 0, 6'd0, 12'h000, 1, 0, lat);
    expectResult("div_zero", 1, 0, 6'd0, 12'h000, 3'b000, 0, 1);
    consume("div_zero");

    applyStimulus(0, 6'd0, 12'h000, 0, 1, 0, 6'd0, 12'h000, 0, 0, lat);
    expectResult("a_nar", 1, 0, 6'd0, 12'h000, 3'b000, 0, 1);
    consume("a_nar");

    applyStimulus(0, 6'd0, 12'h000, 1, 0, 0, 6'd0, 12'h000, 0, 0, lat);
    expectResult("a_zero", 1, 0, 6'd0, 12'h000, 3'b000, 1, 0);
    consume("a_zero");

    // Scale saturation: 28 - (-28) clamps to maxpos, reverse to minpos
    applyStimulus(0, 6'd28, 12'h000, 0, 0, 0, 6'h24, 12'h000, 0, 0, lat);
    expectResult("sat_hi", FW + 6, 0, 6'd28, 12'h000, 3'b000, 0, 0);
    consume("sat_hi");

    applyStimulus(0, 6'h24, 12'h000, 0, 0, 0, 6'd28, 12'h000, 0, 0, lat);
    expectResult("sat_lo", FW + 6, 0, 6'h24, 12'h000, 3'b000, 0, 0);
    consume("sat_lo");

    // Downstream stall with a competing operand pair offered meanwhile
    applyStimulus(0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h800, 0, 0, lat);
    driveOperands(1, 6'd2, 12'hFFF, 0, 0, 0, 6'd1, 12'h001, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_frac", 32'(out_fraction), 32'h555);
      checkOutput("stall_scale", 32'(out_scale), 32'h3F);
    end
    in_valid = 1'b0;
    consume("stall");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_dropped", 32'(out_valid), 32'd0);

    // Reset while dividing abandons the operation
    driveOperands(0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h800, 0, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (FW + 8) @(posedge clk);
    #1;
    checkOutput("midrst_no_output", 32'(out_valid), 32'd0);

    applyStimulus(1, 6'd1, 12'h800, 0, 0, 0, 6'd1, 12'h000, 0, 0, lat);
    expectResult("after_rst", FW + 6, 1, 6'd0, 12'h800, 3'b000, 0, 0);
    consume("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
